// File: rtl/control_state_decoder.sv
// control_state_decoder
// Control-unit state register fed by the IR encoder's next-state code.
// It sequences fetch / decode / execute, including multi-step STRB sub-steps.
// All strobes are a Moore decode of the registered State/Step.
// Illegal is registered, so it pulses for the cycle that follows the offending edge.
// Build option: define MOC_TIMEOUT_EN to bound MOC waits with a 4-bit counter.
// A wait that times out returns to fetch and raises Illegal as a memory fault.
module control_state_decoder #(
  parameter logic [6:0] FETCH_ST    = 7'h01,
  parameter logic [3:0] TIMEOUT_CYC = 4'd15
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [6:0] EncState,
  input  logic       Cond,
  input  logic       Ubit,
  input  logic       MOC,
  output logic [6:0] State,
  output logic [1:0] Step,
  output logic       IR_LE,
  output logic       PC_LE,
  output logic       MAR_LE,
  output logic       MDR_LE,
  output logic       RF_LE,
  output logic       MemEn,
  output logic       MemRW,
  output logic       MA_Sel,
  output logic [1:0] ALU_Op,
  output logic       Illegal
);

  typedef enum logic [6:0] {
    S_RESET   = 7'h00,
    S_F1      = 7'h01,
    S_F2      = 7'h02,
    S_F3      = 7'h03,
    S_DECODE  = 7'h04,
    S_ADD_IMM = 7'h05,
    S_ADD_SHF = 7'h06,
    S_ADD_REG = 7'h07,
    S_OFF_A   = 7'h08,
    S_OFF_B   = 7'h0C,
    S_OFF_C   = 7'h10,
    S_OFF_D   = 7'h14,
    S_PRE_A   = 7'h18,
    S_PRE_B   = 7'h1D,
    S_PRE_C   = 7'h22,
    S_POST_A  = 7'h2C,
    S_POST_B  = 7'h31,
    S_POST_C  = 7'h36,
    S_POST_D  = 7'h3B,
    S_BRANCH  = 7'h40
  } state_t;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_ADD4 = 2'd3;

  localparam logic [1:0] STEP_ADDR  = 2'd0;
  localparam logic [1:0] STEP_DATA  = 2'd1;
  localparam logic [1:0] STEP_WRITE = 2'd2;
  localparam logic [1:0] STEP_WB    = 2'd3;

  // Codes the decoder is allowed to jump to from DECODE.
  function automatic logic f_is_legal(input logic [6:0] code);
    logic ok;
    case (code)
      7'h05, 7'h06, 7'h07, 7'h08, 7'h0C, 7'h10, 7'h14,
      7'h18, 7'h1D, 7'h22, 7'h2C, 7'h31, 7'h36, 7'h3B, 7'h40: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Offset-class STRB: no write-back step.
  function automatic logic f_is_offset(input state_t s);
    logic hit;
    case (s)
      S_OFF_A, S_OFF_B, S_OFF_C, S_OFF_D: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Post-index STRB: the address is Rn unmodified.
  function automatic logic f_is_post(input state_t s);
    logic hit;
    case (s)
      S_POST_A, S_POST_B, S_POST_C, S_POST_D: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  state_t     r_state;
  logic [1:0] r_step;
  logic       r_illegal;

  state_t     w_next_state;
  logic [1:0] w_next_step;
  logic       w_illegal;
  logic       w_wait;
  logic       w_timeout;
  logic [1:0] w_ubit_op;

`ifdef MOC_TIMEOUT_EN
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_inc;

  assign w_wait_inc = r_wait_cnt + 4'd1;
  assign w_timeout  = (~MOC) & (w_wait_inc == TIMEOUT_CYC);

  // Wait counter: counts MOC-low cycles while waiting; it is zero whenever no wait is in progress.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_wait && !MOC && !w_timeout) begin
      r_wait_cnt <= w_wait_inc;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end
`else
  logic [4:0] w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = {w_wait, TIMEOUT_CYC};
`endif

  assign w_ubit_op = Ubit ? ALU_ADD : ALU_SUB;

  // Next-state, next-step and Moore strobe decode of the registered state.
  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    w_illegal    = 1'b0;
    w_wait       = 1'b0;
    IR_LE        = 1'b0;
    PC_LE        = 1'b0;
    MAR_LE       = 1'b0;
    MDR_LE       = 1'b0;
    RF_LE        = 1'b0;
    MemEn        = 1'b0;
    MemRW        = 1'b0;
    MA_Sel       = 1'b0;
    ALU_Op       = ALU_PASS;
    case (r_state)
      S_RESET: begin
        w_next_state = state_t'(FETCH_ST);
        w_next_step  = STEP_ADDR;
      end
      S_F1: begin
        MAR_LE       = 1'b1;
        MA_Sel       = 1'b1;
        w_next_state = S_F2;
        w_next_step  = STEP_ADDR;
      end
      S_F2: begin
        MemEn  = 1'b1;
        MemRW  = 1'b1;
        MDR_LE = 1'b1;
        w_wait = 1'b1;
        if (MOC) begin
          w_next_state = S_F3;
        end else if (w_timeout) begin
          w_next_state = state_t'(FETCH_ST);
          w_next_step  = STEP_ADDR;
          w_illegal    = 1'b1;
        end else begin
          w_next_state = S_F2;
        end
      end
      S_F3: begin
        IR_LE        = 1'b1;
        PC_LE        = 1'b1;
        ALU_Op       = ALU_ADD4;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_step = STEP_ADDR;
        if (!Cond) begin
          w_next_state = state_t'(FETCH_ST);
        end else if (f_is_legal(EncState)) begin
          w_next_state = state_t'(EncState);
        end else begin
          w_next_state = state_t'(FETCH_ST);
          w_illegal    = 1'b1;
        end
      end
      S_ADD_IMM, S_ADD_SHF, S_ADD_REG: begin
        RF_LE        = 1'b1;
        ALU_Op       = ALU_ADD;
        w_next_state = state_t'(FETCH_ST);
        w_next_step  = STEP_ADDR;
      end
      S_BRANCH: begin
        PC_LE        = 1'b1;
        ALU_Op       = ALU_ADD;
        w_next_state = state_t'(FETCH_ST);
        w_next_step  = STEP_ADDR;
      end
      S_OFF_A, S_OFF_B, S_OFF_C, S_OFF_D,
      S_PRE_A, S_PRE_B, S_PRE_C,
      S_POST_A, S_POST_B, S_POST_C, S_POST_D: begin
        case (r_step)
          STEP_ADDR: begin
            MAR_LE      = 1'b1;
            ALU_Op      = f_is_post(r_state) ? ALU_PASS : w_ubit_op;
            w_next_step = STEP_DATA;
          end
          STEP_DATA: begin
            MDR_LE      = 1'b1;
            w_next_step = STEP_WRITE;
          end
          STEP_WRITE: begin
            MemEn  = 1'b1;
            w_wait = 1'b1;
            if (MOC) begin
              if (f_is_offset(r_state)) begin
                w_next_state = state_t'(FETCH_ST);
                w_next_step  = STEP_ADDR;
              end else begin
                w_next_step  = STEP_WB;
              end
            end else if (w_timeout) begin
              w_next_state = state_t'(FETCH_ST);
              w_next_step  = STEP_ADDR;
              w_illegal    = 1'b1;
            end else begin
              w_next_step  = STEP_WRITE;
            end
          end
          STEP_WB: begin
            // Offset class never reaches WB; treat it as a corrupted step and return quietly.
            if (!f_is_offset(r_state)) begin
              RF_LE  = 1'b1;
              ALU_Op = w_ubit_op;
            end else begin
              RF_LE  = 1'b0;
            end
            w_next_state = state_t'(FETCH_ST);
            w_next_step  = STEP_ADDR;
          end
          default: begin
            w_next_state = state_t'(FETCH_ST);
            w_next_step  = STEP_ADDR;
          end
        endcase
      end
      default: begin
        w_next_state = state_t'(FETCH_ST);
        w_next_step  = STEP_ADDR;
      end
    endcase
  end

  // State, sub-step and Illegal pulse registers; an asynchronous reset aborts any wait.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_RESET;
      r_step    <= STEP_ADDR;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_step    <= w_next_step;
      r_illegal <= w_illegal;
    end
  end

  assign State   = r_state;
  assign Step    = r_step;
  assign Illegal = r_illegal;

endmodule

// File: tb/tb_control_state_decoder.sv
// tb_control_state_decoder
// Scoreboard bench: each cycle's inputs are queued together with the expected state/strobes.
// The expectation is popped and compared half a cycle after the next rising edge.
// Expected vector layout: {State[6:0], Step[1:0], IR, PC, MAR, MDR, RF, MemEn, MemRW, MA_Sel, ALU_Op[1:0], Illegal}
module tb_control_state_decoder;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [6:0] EncState;
  logic       Cond;
  logic       Ubit;
  logic       MOC;
  logic [6:0] State;
  logic [1:0] Step;
  logic       IR_LE, PC_LE, MAR_LE, MDR_LE, RF_LE, MemEn, MemRW, MA_Sel, Illegal;
  logic [1:0] ALU_Op;

  int checks = 0;
  int errors = 0;

  logic [9:0]  stim_q[$];
  logic [19:0] exp_q[$];

  localparam logic [10:0] B_IR   = 11'h400;
  localparam logic [10:0] B_PC   = 11'h200;
  localparam logic [10:0] B_MAR  = 11'h100;
  localparam logic [10:0] B_MDR  = 11'h080;
  localparam logic [10:0] B_RF   = 11'h040;
  localparam logic [10:0] B_MEN  = 11'h020;
  localparam logic [10:0] B_MRW  = 11'h010;
  localparam logic [10:0] B_MAS  = 11'h008;
  localparam logic [10:0] A_ADD  = 11'h002;
  localparam logic [10:0] A_SUB  = 11'h004;
  localparam logic [10:0] A_ADD4 = 11'h006;
  localparam logic [10:0] B_ILL  = 11'h001;
  localparam logic [10:0] C_NONE = 11'h000;
  localparam logic [10:0] C_F1   = B_MAR | B_MAS;
  localparam logic [10:0] C_F2   = B_MEN | B_MRW | B_MDR;
  localparam logic [10:0] C_F3   = B_IR | B_PC | A_ADD4;

  control_state_decoder dut (
    .Clk(Clk), .Rst_n(Rst_n), .EncState(EncState), .Cond(Cond), .Ubit(Ubit), .MOC(MOC),
    .State(State), .Step(Step), .IR_LE(IR_LE), .PC_LE(PC_LE), .MAR_LE(MAR_LE),
    .MDR_LE(MDR_LE), .RF_LE(RF_LE), .MemEn(MemEn), .MemRW(MemRW), .MA_Sel(MA_Sel),
    .ALU_Op(ALU_Op), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  function automatic logic [19:0] observe();
    return {State, Step, IR_LE, PC_LE, MAR_LE, MDR_LE, RF_LE, MemEn, MemRW, MA_Sel, ALU_Op, Illegal};
  endfunction

  task automatic push(input logic moc, input logic cond, input logic ubit, input logic [6:0] enc,
                      input logic [6:0] st, input logic [1:0] stp, input logic [10:0] ctrl);
    stim_q.push_back({moc, cond, ubit, enc});
    exp_q.push_back({st, stp, ctrl});
  endtask

  // S1 -> S2 -> S3 -> S4 with memory answering at once.
  task automatic push_fetch();
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h02, 2'd0, C_F2);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h03, 2'd0, C_F3);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h04, 2'd0, C_NONE);
  endtask

  task automatic test_reset();
    logic [19:0] o;
    Rst_n = 1'b0; MOC = 1'b1; Cond = 1'b0; Ubit = 1'b0; EncState = 7'h00;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    o = observe();
    checks++;
    if (o !== 20'h00000) begin
      errors++;
      $display("FAIL reset: got %h expected %h", o, 20'h00000);
    end
    Rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [19:0] e, o; int cyc = 0;
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h01, 2'd0, C_F1);
    push_fetch();
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h01, 2'd0, C_F1);
    push(1'b0, 1'b0, 1'b0, 7'h00, 7'h02, 2'd0, C_F2);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 7'h00, 7'h02, 2'd0, C_F2);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h03, 2'd0, C_F3);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h04, 2'd0, C_NONE);
    while (exp_q.size() > 0) begin
      {MOC, Cond, Ubit, EncState} = stim_q.pop_front();
      @(posedge Clk); @(negedge Clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL fetch cyc%0d: got %h expected %h", cyc, o, e); end
      cyc++;
    end
  endtask

  task automatic test_add_branch();
    logic [19:0] e, o; int cyc = 0;
    push(1'b1, 1'b1, 1'b0, 7'h05, 7'h05, 2'd0, B_RF | A_ADD);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h01, 2'd0, C_F1);
    push_fetch();
    push(1'b1, 1'b1, 1'b0, 7'h40, 7'h40, 2'd0, B_PC | A_ADD);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h01, 2'd0, C_F1);
    push_fetch();
    while (exp_q.size() > 0) begin
      {MOC, Cond, Ubit, EncState} = stim_q.pop_front();
      @(posedge Clk); @(negedge Clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL add_branch cyc%0d: got %h expected %h", cyc, o, e); end
      cyc++;
    end
  endtask

  task automatic test_strb();
    logic [19:0] e, o; int cyc = 0;
    // Pre-index, subtract, write completes on its first cycle.
    push(1'b1, 1'b1, 1'b0, 7'h18, 7'h18, 2'd0, B_MAR | A_SUB);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h18, 2'd1, B_MDR);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h18, 2'd2, B_MEN);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h18, 2'd3, B_RF | A_SUB);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h01, 2'd0, C_F1);
    push_fetch();
    // Offset, add, write waits one extra cycle for MOC.
    push(1'b1, 1'b1, 1'b1, 7'h0C, 7'h0C, 2'd0, B_MAR | A_ADD);
    push(1'b1, 1'b0, 1'b1, 7'h00, 7'h0C, 2'd1, B_MDR);
    push(1'b0, 1'b0, 1'b1, 7'h00, 7'h0C, 2'd2, B_MEN);
    push(1'b0, 1'b0, 1'b1, 7'h00, 7'h0C, 2'd2, B_MEN);
    push(1'b1, 1'b0, 1'b1, 7'h00, 7'h01, 2'd0, C_F1);
    push_fetch();
    // Post-index, add: address step passes Rn, write-back adds.
    push(1'b1, 1'b1, 1'b1, 7'h2C, 7'h2C, 2'd0, B_MAR);
    push(1'b1, 1'b0, 1'b1, 7'h00, 7'h2C, 2'd1, B_MDR);
    push(1'b1, 1'b0, 1'b1, 7'h00, 7'h2C, 2'd2, B_MEN);
    push(1'b1, 1'b0, 1'b1, 7'h00, 7'h2C, 2'd3, B_RF | A_ADD);
    push(1'b1, 1'b0, 1'b1, 7'h00, 7'h01, 2'd0, C_F1);
    push_fetch();
    while (exp_q.size() > 0) begin
      {MOC, Cond, Ubit, EncState} = stim_q.pop_front();
      @(posedge Clk); @(negedge Clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL strb cyc%0d: got %h expected %h", cyc, o, e); end
      cyc++;
    end
  endtask

  task automatic test_decode_reject();
    logic [19:0] e, o; int cyc = 0;
    push(1'b1, 1'b0, 1'b0, 7'h40, 7'h01, 2'd0, C_F1);
    push_fetch();
    push(1'b1, 1'b1, 1'b0, 7'h09, 7'h01, 2'd0, C_F1 | B_ILL);
    push_fetch();
    while (exp_q.size() > 0) begin
      {MOC, Cond, Ubit, EncState} = stim_q.pop_front();
      @(posedge Clk); @(negedge Clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL decode_reject cyc%0d: got %h expected %h", cyc, o, e); end
      cyc++;
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] e, o; int cyc = 0;
    push(1'b1, 1'b1, 1'b0, 7'h2C, 7'h2C, 2'd0, B_MAR);
    push(1'b0, 1'b0, 1'b0, 7'h00, 7'h2C, 2'd1, B_MDR);
    push(1'b0, 1'b0, 1'b0, 7'h00, 7'h2C, 2'd2, B_MEN);
    while (exp_q.size() > 0) begin
      {MOC, Cond, Ubit, EncState} = stim_q.pop_front();
      @(posedge Clk); @(negedge Clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL async_reset cyc%0d: got %h expected %h", cyc, o, e); end
      cyc++;
    end
    #2 Rst_n = 1'b0;
    #1 o = observe();
    checks++;
    if (o !== 20'h00000) begin
      errors++;
      $display("FAIL async_reset mid-write: got %h expected %h", o, 20'h00000);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    push(1'b0, 1'b0, 1'b0, 7'h00, 7'h01, 2'd0, C_F1);
    while (exp_q.size() > 0) begin
      {MOC, Cond, Ubit, EncState} = stim_q.pop_front();
      @(posedge Clk); @(negedge Clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL async_release cyc%0d: got %h expected %h", cyc, o, e); end
      cyc++;
    end
  endtask

  task automatic test_moc_timeout();
    logic [19:0] e, o; int cyc = 0;
    push(1'b0, 1'b0, 1'b0, 7'h00, 7'h02, 2'd0, C_F2);
`ifdef MOC_TIMEOUT_EN
    for (int i = 0; i < 14; i++) push(1'b0, 1'b0, 1'b0, 7'h00, 7'h02, 2'd0, C_F2);
    push(1'b0, 1'b0, 1'b0, 7'h00, 7'h01, 2'd0, C_F1 | B_ILL);
    push(1'b0, 1'b0, 1'b0, 7'h00, 7'h02, 2'd0, C_F2);
`else
    for (int i = 0; i < 20; i++) push(1'b0, 1'b0, 1'b0, 7'h00, 7'h02, 2'd0, C_F2);
`endif
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h03, 2'd0, C_F3);
    push(1'b1, 1'b0, 1'b0, 7'h00, 7'h04, 2'd0, C_NONE);
    while (exp_q.size() > 0) begin
      {MOC, Cond, Ubit, EncState} = stim_q.pop_front();
      @(posedge Clk); @(negedge Clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL moc_timeout cyc%0d: got %h expected %h", cyc, o, e); end
      cyc++;
    end
  endtask

  // Main sequence: each scenario starts where the previous one left the machine.
  initial begin
    test_reset();
    test_fetch();
    test_add_branch();
    test_strb();
    test_decode_reject();
    test_async_reset();
    test_moc_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
